// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types and constants.
// Holds the word type, the fetch-stage state encoding and the reset PC.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } lc3b_fetch_state;

    localparam lc3b_word LC3B_RESET_PC = 16'h0000;

    // Instruction addresses are word aligned; bit 0 is always dropped.
    function automatic lc3b_word align_pc(input lc3b_word addr);
        return {addr[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Single-entry skid buffer for a fetched instruction and its PC+2.
// Captures a response that arrives while decode is stalled.
module fetch_skid_buffer
    import lc3b_types::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     load,
    input  logic     clear,
    input  lc3b_word load_ir,
    input  lc3b_word load_pc2,
    output lc3b_word ir,
    output lc3b_word pc2,
    output logic     valid
);

    // Clear wins over load so a redirect can never leave a stale entry behind.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ir    <= 16'h0000;
            pc2   <= 16'h0000;
            valid <= 1'b0;
        end else if (clear) begin
            ir    <= 16'h0000;
            pc2   <= 16'h0000;
            valid <= 1'b0;
        end else if (load) begin
            ir    <= load_ir;
            pc2   <= load_pc2;
            valid <= 1'b1;
        end else begin
            ir    <= ir;
            pc2   <= pc2;
            valid <= valid;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// LC-3b fetch stage: owns the PC, drives the instruction memory port and
// loads the IF/ID register, handling stall, redirect and multi-cycle memory.
module instruction_fetch
    import lc3b_types::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     stall,
    input  logic     redirect,
    input  lc3b_word redirect_pc,
    output lc3b_word imem_address,
    output logic     imem_read,
    input  lc3b_word imem_rdata,
    input  logic     imem_resp,
    output lc3b_word ir_out,
    output lc3b_word pc_out,
    output logic     if_bubble
);

    lc3b_fetch_state state_r, state_next_s;
    lc3b_word        pc_r, pc_next_s;
    lc3b_word        target_r, target_next_s;
    lc3b_word        ir_next_s, pc_out_next_s;
    logic            bubble_next_s;
    logic            skid_load_s, skid_clear_s, skid_valid_s;
    lc3b_word        skid_ir_s, skid_pc2_s;
    lc3b_word        pc_plus2_s, redirect_aligned_s;

    assign pc_plus2_s         = pc_r + 16'd2;
    assign redirect_aligned_s = align_pc(redirect_pc);

    // The memory port depends only on registered state, never on stall/redirect.
    assign imem_address = pc_r;
    assign imem_read    = (state_r == FETCH) || (state_r == DRAIN);

    fetch_skid_buffer u_skid (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (skid_load_s),
        .clear    (skid_clear_s),
        .load_ir  (imem_rdata),
        .load_pc2 (pc_plus2_s),
        .ir       (skid_ir_s),
        .pc2      (skid_pc2_s),
        .valid    (skid_valid_s)
    );

    // Next-state, next-PC and next IF/ID contents.
    always_comb begin
        state_next_s  = state_r;
        pc_next_s     = pc_r;
        target_next_s = target_r;
        ir_next_s     = ir_out;
        pc_out_next_s = pc_out;
        bubble_next_s = if_bubble;
        skid_load_s   = 1'b0;
        skid_clear_s  = 1'b0;

        case (state_r)
            RESET: begin
                pc_next_s     = LC3B_RESET_PC;
                target_next_s = LC3B_RESET_PC;
                ir_next_s     = 16'h0000;
                pc_out_next_s = 16'h0000;
                bubble_next_s = 1'b1;
                skid_clear_s  = 1'b1;
                state_next_s  = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    ir_next_s     = 16'h0000;
                    bubble_next_s = 1'b1;
                    if (imem_resp) begin
                        pc_next_s = redirect_aligned_s;
                    end else begin
                        target_next_s = redirect_aligned_s;
                        state_next_s  = DRAIN;
                    end
                end else if (imem_resp) begin
                    pc_next_s = pc_plus2_s;
                    if (stall) begin
                        skid_load_s  = 1'b1;
                        state_next_s = HOLD;
                    end else begin
                        ir_next_s     = imem_rdata;
                        pc_out_next_s = pc_plus2_s;
                        bubble_next_s = 1'b0;
                    end
                end else if (!stall) begin
                    ir_next_s     = 16'h0000;
                    bubble_next_s = 1'b1;
                end else begin
                    state_next_s = FETCH;
                end
            end
            HOLD: begin
                if (redirect) begin
                    skid_clear_s  = 1'b1;
                    pc_next_s     = redirect_aligned_s;
                    ir_next_s     = 16'h0000;
                    bubble_next_s = 1'b1;
                    state_next_s  = FETCH;
                end else if (!stall) begin
                    ir_next_s     = skid_ir_s;
                    pc_out_next_s = skid_pc2_s;
                    bubble_next_s = ~skid_valid_s;
                    skid_clear_s  = 1'b1;
                    state_next_s  = FETCH;
                end else begin
                    state_next_s = HOLD;
                end
            end
            DRAIN: begin
                // The read in flight must complete; only the latest target survives.
                if (redirect) begin
                    ir_next_s     = 16'h0000;
                    bubble_next_s = 1'b1;
                    target_next_s = redirect_aligned_s;
                end else begin
                    target_next_s = target_r;
                end
                if (imem_resp) begin
                    pc_next_s    = redirect ? redirect_aligned_s : target_r;
                    state_next_s = FETCH;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: begin
                state_next_s = RESET;
            end
        endcase
    end

    // State, PC and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= RESET;
            pc_r      <= LC3B_RESET_PC;
            target_r  <= LC3B_RESET_PC;
            ir_out    <= 16'h0000;
            pc_out    <= 16'h0000;
            if_bubble <= 1'b1;
        end else begin
            state_r   <= state_next_s;
            pc_r      <= pc_next_s;
            target_r  <= target_next_s;
            ir_out    <= ir_next_s;
            pc_out    <= pc_out_next_s;
            if_bubble <= bubble_next_s;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed, table-driven bench for instruction_fetch.
// Each row drives one cycle, checks the memory port before the edge and IF/ID after it.
module tb_instruction_fetch;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] imem_address;
    logic        imem_read;
    logic [15:0] imem_rdata;
    logic        imem_resp;
    logic [15:0] ir_out;
    logic [15:0] pc_out;
    logic        if_bubble;

    int checks   = 0;
    int failures = 0;

    instruction_fetch dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_address (imem_address),
        .imem_read    (imem_read),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .ir_out       (ir_out),
        .pc_out       (pc_out),
        .if_bubble    (if_bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        stl;
        logic        rdr;
        logic [15:0] rpc;
        logic        resp;
        logic [15:0] rdata;
        logic        e_read;
        logic [15:0] e_addr;
        logic [15:0] e_ir;
        logic [15:0] e_pc;
        logic        e_bub;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst_n_v, input logic stl, input logic rdr, input logic [15:0] rpc,
                       input logic resp, input logic [15:0] rdata, input logic e_read,
                       input logic [15:0] e_addr, input logic [15:0] e_ir,
                       input logic [15:0] e_pc, input logic e_bub);
        vec_t v;
        v.rst_n = rst_n_v; v.stl = stl; v.rdr = rdr; v.rpc = rpc; v.resp = resp; v.rdata = rdata;
        v.e_read = e_read; v.e_addr = e_addr; v.e_ir = e_ir; v.e_pc = e_pc; v.e_bub = e_bub;
        vecs.push_back(v);
    endtask

    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        reset_n     = v.rst_n;
        stall       = v.stl;
        redirect    = v.rdr;
        redirect_pc = v.rpc;
        imem_resp   = v.resp;
        imem_rdata  = v.rdata;
        #1;
        chk({tag, " imem_read"}, {15'd0, imem_read}, {15'd0, v.e_read});
        chk({tag, " imem_address"}, imem_address, v.e_addr);
        @(posedge clk);
        #1;
        chk({tag, " ir_out"}, ir_out, v.e_ir);
        chk({tag, " pc_out"}, pc_out, v.e_pc);
        chk({tag, " if_bubble"}, {15'd0, if_bubble}, {15'd0, v.e_bub});
    endtask

    initial begin
        vec_t h;
        reset_n     = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        imem_resp   = 1'b0;
        imem_rdata  = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ir_out", ir_out, 16'h0000);
        chk("reset pc_out", pc_out, 16'h0000);
        chk("reset if_bubble", {15'd0, if_bubble}, 16'h0001);
        chk("reset imem_read", {15'd0, imem_read}, 16'h0000);

        //  rst stl rdr rpc       rsp rdata     | rd addr      ir        pc        bub
        add(1, 0, 0, 16'h0000, 0, 16'h0000,   0, 16'h0000, 16'h0000, 16'h0000, 1);
        add(1, 0, 0, 16'h0000, 1, 16'h1234,   1, 16'h0000, 16'h1234, 16'h0002, 0);
        add(1, 0, 0, 16'h0000, 1, 16'h1111,   1, 16'h0002, 16'h1111, 16'h0004, 0);
        // slow memory: two bubbles, address held
        add(1, 0, 0, 16'h0000, 0, 16'h0000,   1, 16'h0004, 16'h0000, 16'h0004, 1);
        add(1, 0, 0, 16'h0000, 0, 16'h0000,   1, 16'h0004, 16'h0000, 16'h0004, 1);
        add(1, 0, 0, 16'h0000, 1, 16'h2222,   1, 16'h0004, 16'h2222, 16'h0006, 0);
        // stall as 0x5678 returns
        add(1, 1, 0, 16'h0000, 1, 16'h5678,   1, 16'h0006, 16'h2222, 16'h0006, 0);
        add(1, 1, 0, 16'h0000, 0, 16'h0000,   0, 16'h0008, 16'h2222, 16'h0006, 0);
        add(1, 1, 0, 16'h0000, 0, 16'h0000,   0, 16'h0008, 16'h2222, 16'h0006, 0);
        add(1, 0, 0, 16'h0000, 0, 16'h0000,   0, 16'h0008, 16'h5678, 16'h0008, 0);
        add(1, 0, 0, 16'h0000, 1, 16'h3333,   1, 16'h0008, 16'h3333, 16'h000A, 0);
        // redirect with a pending read drains the old address
        add(1, 0, 1, 16'h3001, 0, 16'h0000,   1, 16'h000A, 16'h0000, 16'h000A, 1);
        add(1, 0, 0, 16'h0000, 0, 16'h0000,   1, 16'h000A, 16'h0000, 16'h000A, 1);
        add(1, 0, 0, 16'h0000, 1, 16'hDEAD,   1, 16'h000A, 16'h0000, 16'h000A, 1);
        add(1, 0, 0, 16'h0000, 1, 16'h4444,   1, 16'h3000, 16'h4444, 16'h3002, 0);
        // stall and redirect together in FETCH
        add(1, 1, 1, 16'h0100, 1, 16'h5555,   1, 16'h3002, 16'h0000, 16'h3002, 1);
        add(1, 0, 0, 16'h0000, 1, 16'h6666,   1, 16'h0100, 16'h6666, 16'h0102, 0);
        // stall and redirect together in HOLD drop the skid entry
        add(1, 1, 0, 16'h0000, 1, 16'h7777,   1, 16'h0102, 16'h6666, 16'h0102, 0);
        add(1, 1, 1, 16'h0201, 0, 16'h0000,   0, 16'h0104, 16'h0000, 16'h0102, 1);
        add(1, 0, 0, 16'h0000, 1, 16'h8888,   1, 16'h0200, 16'h8888, 16'h0202, 0);
        // repeated redirect in DRAIN: latest target wins
        add(1, 0, 1, 16'h0400, 0, 16'h0000,   1, 16'h0202, 16'h0000, 16'h0202, 1);
        add(1, 0, 1, 16'h0500, 0, 16'h0000,   1, 16'h0202, 16'h0000, 16'h0202, 1);
        add(1, 0, 0, 16'h0000, 1, 16'h9999,   1, 16'h0202, 16'h0000, 16'h0202, 1);
        add(1, 0, 0, 16'h0000, 0, 16'h0000,   1, 16'h0500, 16'h0000, 16'h0202, 1);
        // PC wrap at 0xFFFE
        add(1, 0, 1, 16'hFFFE, 1, 16'h0BAD,   1, 16'h0500, 16'h0000, 16'h0202, 1);
        add(1, 0, 0, 16'h0000, 1, 16'hABCD,   1, 16'hFFFE, 16'hABCD, 16'h0000, 0);
        // reset in the middle of a DRAIN
        add(1, 0, 1, 16'h1000, 0, 16'h0000,   1, 16'h0000, 16'h0000, 16'h0000, 1);
        add(0, 0, 0, 16'h0000, 0, 16'h0000,   1, 16'h0000, 16'h0000, 16'h0000, 1);
        add(1, 0, 0, 16'h0000, 0, 16'h0000,   0, 16'h0000, 16'h0000, 16'h0000, 1);
        add(1, 0, 0, 16'h0000, 1, 16'h1234,   1, 16'h0000, 16'h1234, 16'h0002, 0);

        foreach (vecs[i]) begin
            step(vecs[i], $sformatf("row%0d", i));
        end

        // Hand sequence: reset while holding a skid entry must discard it.
        h = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 1'b1, 16'h0002, 16'h1234, 16'h0002, 1'b0};
        step(h, "hold_enter");
        h = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0004, 16'h0000, 16'h0000, 1'b1};
        step(h, "hold_reset");
        h = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        step(h, "hold_release");
        h = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hC0DE, 1'b1, 16'h0000, 16'hC0DE, 16'h0002, 1'b0};
        step(h, "hold_refetch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the LC-3b pipeline, directly upstream of instruction decode. Owns the PC, issues instruction reads to the instruction memory port, and presents the fetched instruction (with its PC+2) to decode through the IF/ID register. Handles downstream stall, branch redirect with flush, and memory latency of one or more cycles. When no valid instruction is available, it signals a bubble so decode inserts a NOP.

## Interface
- No parameters; widths come from `lc3b_types` (`lc3b_word` = 16 bits).
- `clk` in 1: single clock, all state updates on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `stall` in 1: decode/hazard unit freezes IF/ID; hold `ir_out`/`pc_out`.
- `redirect` in 1: taken branch/jump resolved downstream; flush and refetch.
- `redirect_pc` in 16: new fetch address; bit 0 forced to 0.
- `imem_address` out 16: instruction read address.
- `imem_read` out 1: read request; held with a stable address until `imem_resp`.
- `imem_rdata` in 16: instruction word, valid when `imem_resp`=1.
- `imem_resp` in 1: read complete (same cycle or later).
- `ir_out` out 16: IF/ID instruction register, feeding decode `IR`.
- `pc_out` out 16: IF/ID PC+2 of `ir_out`.
- `if_bubble` out 1: `ir_out` invalid; drives decode `gen_bubble`.

## Operation
- State enum: RESET, FETCH, HOLD, DRAIN.
- Registers: `pc`, `target`, skid buffer {ir, pc2}, and IF/ID {`ir_out`, `pc_out`, `if_bubble`}.
- RESET sets `pc`=0x0000, `target`=0x0000, `ir_out`=0x0000, `pc_out`=0x0000, `if_bubble`=1, `imem_read`=0, and clears the skid buffer. Always goes to FETCH next cycle.
- FETCH: `imem_read`=1, `imem_address`=`pc`. Priority is redirect > stall > normal.
  - `redirect` & `imem_resp`: discard data, `pc`<=`redirect_pc`, stay FETCH.
  - `redirect` & !`imem_resp`: `target`<=`redirect_pc`, go DRAIN.
  - `imem_resp` & `stall`: skid<={`imem_rdata`, `pc`+2}, `pc`<=`pc`+2, go HOLD.
  - `imem_resp` & !`stall`: IF/ID<={`imem_rdata`, `pc`+2, 0}, `pc`<=`pc`+2.
  - !`imem_resp` & !`stall`: IF/ID bubble (`ir_out`<=0x0000, `if_bubble`<=1; `pc_out` holds).
- HOLD: `imem_read`=0.
  - `redirect`: drop skid, `pc`<=`redirect_pc`, go FETCH.
  - Else !`stall`: IF/ID<=skid, `if_bubble`<=0, go FETCH.
  - Else stay.
- DRAIN: `imem_read`=1 on the old `pc`. The outstanding read is never abandoned.
  - Further `redirect` overwrites `target` (latest wins).
  - On `imem_resp`: discard data, `pc`<=`target`, go FETCH.
- `redirect` in any non-RESET state forces IF/ID to bubble, even when `stall`=1.
- `stall` without `redirect` holds IF/ID unchanged.
- PC arithmetic is modulo 2^16; 0xFFFE+2 wraps to 0x0000.

## Timing
- `imem_read` and `imem_address` decode from registered state/`pc` only. There is no combinational path from `stall`/`redirect` to the memory port.
- Fetch-to-decode latency: a response in cycle N is visible on `ir_out` in N+1.
- Throughput: one instruction per cycle with single-cycle memory.
- Redirect penalty: minimum one bubble. Fetch from the new `pc` is issued in the cycle after `redirect`, or after the DRAIN response.
- Reset is sampled at the edge in any state, including mid-read. The memory port deasserts in the cycle after the reset edge.

## Structure
- Add the `lc3b_fetch_state` enum to the `lc3b_types` package. Reuse `lc3b_word`.
- Add constant `LC3B_RESET_PC` = 16'h0000 to the package.
- Sub-module `fetch_skid_buffer`: load/clear register pair {ir, pc2} with a valid bit. All other logic is local.

## Test plan
- Reset, then memory `imem_resp` every cycle with word 0x1234 at 0x0000 -> cycle 2: `ir_out`=0x1234, `pc_out`=0x0002, `if_bubble`=0; addresses step 0x0000, 0x0002, 0x0004.
- `imem_resp` 3 cycles after request -> `if_bubble`=1 for 2 cycles, address stable at 0x0004, `imem_read`=1 held throughout.
- `stall`=1 for 3 cycles as 0x5678 returns -> `ir_out` holds old value; HOLD with `imem_read`=0; on release `ir_out`=0x5678 and the next fetch address is +2.
- `redirect`=1, `redirect_pc`=0x3001 with a pending read (no resp) -> DRAIN; old address held until resp; data discarded; next address 0x3000; `if_bubble`=1 in the interim.
- Simultaneous `stall`=1 and `redirect`=1 -> `if_bubble`=1, `ir_out`=0x0000, next fetch at `redirect_pc`.
- `pc`=0xFFFE fetch, then `reset_n`=0 mid-DRAIN -> wrap to 0x0000 confirmed; reset returns all outputs to reset values the next cycle.
